sevenseg_display_scheduler: RTL
===============================

# sevenseg_display_scheduler

Shares the 4-digit seven-segment display between two requesting clients. Each client presents a 32-bit value. The scheduler grants the display to one client at a time, using round-robin order. While a client holds the grant, the scheduler pages its value through the 16-bit display path, low half first, then high half, for a fixed dwell time per page. `disp_value` feeds the existing number-decoder → 4-digit-driver chain, so the display can show 8 hex digits 4 at a time.

## Interface
- `DWELL_CYCLES`, default 100_000_000: clock cycles each page is shown (≥1). The dwell counter width is `$clog2(DWELL_CYCLES)`, minimum 1.
- `PAGES_PER_GRANT`, default 2: page flips in one grant slot (≥1).
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 2: `req[i]` high means client i wants the display; level-sensitive.
- `value0` in 32: client 0 value.
- `value1` in 32: client 1 value.
- `grant` out 2: one-hot owner, or 00 when no client owns the display.
- `done` out 2: one-cycle pulse on bit i when client i's slot ends.
- `disp_value` out 16: half-word to display.
- `page` out 1: 0 means low half [15:0] is displayed; 1 means high half [31:16].
- `blank` out 1: 1 means nothing is granted and the display should be blanked.

## Operation
- FSM has two states:
  - IDLE: `grant`=00, `blank`=1.
  - SHOW: `grant` is one-hot, `blank`=0.
- IDLE → SHOW when `req`≠00.
  - Winner: if only one `req` bit is set, that client; if both are set, the client ≠ `last_owner`.
  - On entry: `snap`←winner's value, `page`←0, `dwell_cnt`←0, `page_cnt`←0.
- In SHOW, `dwell_cnt` increments every cycle.
  - At `dwell_cnt`==`DWELL_CYCLES`-1: `dwell_cnt`←0, `page` toggles, `page_cnt` increments.
- SHOW → IDLE (slot end) on either condition:
  - Dwell expiry while `page_cnt`==`PAGES_PER_GRANT`-1.
  - `req[owner]` sampled 0 (early release).
- If both end conditions occur in the same cycle, it is a single slot end with a single `done` pulse.
- At slot end: `last_owner`←owner. `done[owner]`=1 during the following IDLE cycle only.
- The IDLE cycle lasts at least 1 cycle, so handover always shows one blank cycle.
- `disp_value` = `page` ? `snap[31:16]` : `snap[15:0]`. `disp_value` holds its last value while in IDLE.
- `value0`/`value1` changes during a slot are ignored (snapshot semantics), unless the live-update macro is defined.
- A `req` from the non-owner during SHOW does not preempt; it is served at the next arbitration.
- Reset values: IDLE, `grant`=00, `done`=00, `disp_value`=0x0000, `page`=0, `blank`=1, `last_owner`=1 (client 0 wins the first tie), all counters 0.
- Reset mid-slot: outputs reach reset values at the next edge; no `done` pulse is emitted.

## Timing
- `req` first sampled high in IDLE in cycle n → `grant`, `disp_value`, and `blank`=0 valid in cycle n+1.
- A full slot lasts `DWELL_CYCLES`×`PAGES_PER_GRANT` cycles. It is followed by one IDLE cycle in which `done` is high.
- Early release: `req[owner]` sampled 0 in SHOW cycle m → IDLE with `done` pulse in cycle m+1.
- Back-to-back service with both clients requesting: a period of slot + 1 cycle per client, alternating 01, 10, 01, ...
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SCHED_LIVE_UPDATE_EN`:
  - When defined: `snap` reloads from the owner's value every SHOW cycle, so `disp_value` tracks the live input with 1-cycle latency.
  - When undefined: the value is latched only at grant.
- Arbitration, paging and timing are identical in both builds.

## Test plan
All tests use `DWELL_CYCLES`=4 and `PAGES_PER_GRANT`=2.
- Reset asserted for 2 cycles → `blank`=1, `grant`=00, `done`=00, `disp_value`=0x0000, `page`=0.
- Single request, then release:
  - Stimulus: `req`=01, `value0`=0xDEADBEEF, sampled in cycle 0.
  - Required: `grant`=01 in cycles 1–8. `disp_value`=0xBEEF with `page`=0 in cycles 1–4; 0xDEAD with `page`=1 in cycles 5–8.
  - Required: cycle 9 is IDLE with `done`=01.
  - Then `req`=00 → IDLE held, `done`=00.
- Both clients request continuously:
  - `grant` sequence is 01 (cycles 1–8), 00 (cycle 9), 10 (cycles 10–17), 00 (cycle 18), 01 (cycles 19–26).
  - `done` pulses 01 at cycle 9 and 10 at cycle 18.
- Owner drops `req` in cycle 3 → cycle 4 is IDLE with `done`=01; the next grant to the other client arrives no earlier than cycle 5.
- Live update, client 0 holding `value0`=0x12345678:
  - Stimulus: change to 0x1234AAAA in cycle 2.
  - Without the macro: `disp_value` stays 0x5678 through cycle 4.
  - With `SCHED_LIVE_UPDATE_EN`: `disp_value`=0xAAAA from cycle 3.
- Reset asserted in cycle 6 of a slot → cycle 7 shows reset values, `done`=00. The next tie goes to client 0.

Source files
------------

// File: rtl/sevenseg_display_scheduler.sv
// sevenseg_display_scheduler
// Grants the shared 4-digit seven-segment display to one of two clients. The
// order is round-robin. The owner's 32-bit value is paged out 16 bits at a
// time: the low half first, then the high half, each page held for
// DWELL_CYCLES cycles.
// Optional build macro: SCHED_LIVE_UPDATE_EN. When it is defined, the
// displayed value follows the owner's live input instead of the value
// captured at grant.
module sevenseg_display_scheduler #(
    parameter int unsigned DWELL_CYCLES    = 100_000_000,
    parameter int unsigned PAGES_PER_GRANT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] value0,
    input  logic [31:0] value1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [15:0] disp_value,
    output logic        page,
    output logic        blank
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned PW = (PAGES_PER_GRANT > 1) ? $clog2(PAGES_PER_GRANT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGES_PER_GRANT - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic [31:0]   snap;
    logic [DW-1:0] dwell_cnt;
    logic [PW-1:0] page_cnt;

    logic          winner;
    logic [31:0]   winner_value;
    logic          owner_req;
    logic          dwell_expire;
    logic          slot_end;

    // Arbitration: a lone requester wins; on a tie the client that did not
    // own the display last time wins.
    assign winner       = (req == 2'b11) ? ~last_owner : req[1];
    assign winner_value = winner ? value1 : value0;

    // A slot ends when its last page expires or when the owner drops req.
    // If both happen in the same cycle, that is one slot end.
    assign owner_req    = owner ? req[1] : req[0];
    assign dwell_expire = (dwell_cnt == DWELL_LAST);
    assign slot_end     = ~owner_req | (dwell_expire & (page_cnt == PAGE_LAST));

    // The display half-word is selected from registered state only. It holds
    // its last value while the scheduler is idle.
    assign disp_value = page ? snap[31:16] : snap[15:0];

    // Scheduler FSM, paging counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            snap       <= 32'h0;
            dwell_cnt  <= '0;
            page_cnt   <= '0;
            grant      <= 2'b00;
            done       <= 2'b00;
            page       <= 1'b0;
            blank      <= 1'b1;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state     <= SHOW;
                        owner     <= winner;
                        grant     <= winner ? 2'b10 : 2'b01;
                        blank     <= 1'b0;
                        snap      <= winner_value;
                        page      <= 1'b0;
                        dwell_cnt <= '0;
                        page_cnt  <= '0;
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        blank      <= 1'b1;
                        last_owner <= owner;
                        done       <= owner ? 2'b10 : 2'b01;
                    end else begin
`ifdef SCHED_LIVE_UPDATE_EN
                        snap <= owner ? value1 : value0;
`endif
                        if (dwell_expire) begin
                            dwell_cnt <= '0;
                            page      <= ~page;
                            page_cnt  <= page_cnt + PW'(1);
                        end else begin
                            dwell_cnt <= dwell_cnt + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
